bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Two-master arbiter and switch for the shared serial bus. Grants one master
//  at a time via its bus_ready. Routes the granted master's serial
//  addr/data/valid/write_en lines to the slave, and the slave's data_rx and
//  slave_valid back to that master only. Uses round-robin fairness, a
//  per-grant watchdog timeout and a one-cycle turnaround between owners.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max clock cycles a grant may be held before forced release
//  CNT_W           9    watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clock           in   1  system clock, all logic on posedge
//  reset           in   1  synchronous, active-high
//  m1_bus_req      in   1  master 1 bus request (level, held for whole transfer)
//  m1_addr_tx      in   1  master 1 serial address bit
//  m1_data_tx      in   1  master 1 serial write-data bit
//  m1_valid_s      in   1  master 1 frame valid to slave
//  m1_write_en     in   1  master 1 write(1)/read(0) select
//  m2_*            in   1  same five inputs for master 2
//  m1_bus_ready    out  1  grant to master 1
//  m2_bus_ready    out  1  grant to master 2
//  m1_data_rx      out  1  slave read data to master 1 (0 when not owner)
//  m2_data_rx      out  1  slave read data to master 2 (0 when not owner)
//  m1_slave_valid  out  1  slave_valid to master 1 (0 when not owner)
//  m2_slave_valid  out  1  slave_valid to master 2 (0 when not owner)
//  s_addr_tx       out  1  muxed address bit to slave
//  s_data_tx       out  1  muxed data bit to slave
//  s_valid_s       out  1  muxed frame valid to slave
//  s_write_en      out  1  muxed write select to slave
//  s_data_rx       in   1  slave serial read data
//  s_slave_valid   in   1  slave read-data valid
//  owner           out  2  0 none, 1 master 1, 2 master 2
//  timeout         out  1  one-cycle pulse when the watchdog revokes a grant
// BEHAVIOUR
//  Reset: state=IDLE; last_owner=2, so master 1 wins the first tie.
//   Watchdog=0, lockout flags=0.
//   All outputs 0; owner=0.
//  FSM states IDLE, GRANT1, GRANT2, RELEASE, all registered:
//   IDLE: eligible request = mX_bus_req & ~lockX.
//    Both eligible -> grant the master != last_owner.
//    One eligible -> grant it. None -> stay in IDLE.
//   GRANTx: mX_bus_ready=1, owner=x.
//    mX_bus_req low -> RELEASE.
//    Watchdog reaching TIMEOUT_CYCLES-1 -> RELEASE, pulse timeout, set lockX.
//   RELEASE: exactly one cycle, all grants 0, last_owner=x -> IDLE.
//  Latency: req high in IDLE -> bus_ready high on the next posedge (1 cycle).
//  Turnaround: minimum 2 cycles between owner A's last grant cycle and owner B's
//   first grant cycle (RELEASE, then IDLE). No back-to-back grants.
//  Watchdog: cleared on entry to GRANTx, +1 per GRANT cycle, saturates,
//   cleared in RELEASE.
//  Lockout: lockX clears when mX_bus_req is sampled low. A timed-out master
//   must drop its request before it can be granted again.
//  Datapath mux is combinational from the registered owner:
//   owner=1 -> s_* = m1_*; owner=2 -> s_* = m2_*.
//   owner=0 (IDLE/RELEASE) -> all s_* = 0, so s_valid_s=0 during turnaround.
//  Return path: s_data_rx and s_slave_valid reach only the owner's ports.
//   The non-owner sees 0.
//  Simultaneous events:
//   - Owner drops req on the same cycle the watchdog expires -> treat as a
//     timeout (pulse, set lock).
//   - New request during RELEASE -> not granted until IDLE is evaluated.
//  Reset mid-grant: next cycle returns all outputs to reset values; the slave
//   sees s_valid_s=0 and the transfer is abandoned.
// TESTING
//  1. Reset, then m1_bus_req=1 -> m1_bus_ready=1 at cycle+1, owner=1;
//     m1_addr_tx toggling appears on s_addr_tx the same cycle.
//  2. m1 and m2 request in the same cycle after reset -> m1 granted. m1 drops
//     req -> RELEASE, IDLE, then m2_bus_ready=1 exactly 2 cycles after m1's
//     last grant cycle.
//  3. m2 holds req, then both request again -> m1 wins (round-robin). Repeat
//     4 times -> grants alternate 1,2,1,2.
//  4. TIMEOUT_CYCLES=16, m1 holds req -> timeout pulse after 16 grant cycles,
//     m1_bus_ready=0. m2 granted if requesting. m1 not regranted until its req
//     drops and rises.
//  5. owner=2, drive s_slave_valid=1, s_data_rx=1 -> m2_slave_valid=1,
//     m2_data_rx=1; m1_slave_valid=0, m1_data_rx=0.
//  6. Assert reset during GRANT1 with m1_valid_s=1 -> next cycle owner=0,
//     s_valid_s=0, m1_bus_ready=0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bundle of the two-master shared serial bus as seen by the arbiter.
// The slave modport is the arbiter side; the master modport is the requesters/slave-device side.
interface bus_arbiter_if;
   logic       m1_bus_req, m1_addr_tx, m1_data_tx, m1_valid_s, m1_write_en;
   logic       m2_bus_req, m2_addr_tx, m2_data_tx, m2_valid_s, m2_write_en;
   logic       m1_bus_ready, m2_bus_ready;
   logic       m1_data_rx, m2_data_rx, m1_slave_valid, m2_slave_valid;
   logic       s_addr_tx, s_data_tx, s_valid_s, s_write_en;
   logic       s_data_rx, s_slave_valid;
   logic [1:0] owner;
   logic       timeout;

   modport slave (
      input  m1_bus_req, m1_addr_tx, m1_data_tx, m1_valid_s, m1_write_en,
      input  m2_bus_req, m2_addr_tx, m2_data_tx, m2_valid_s, m2_write_en,
      input  s_data_rx, s_slave_valid,
      output m1_bus_ready, m2_bus_ready,
      output m1_data_rx, m2_data_rx, m1_slave_valid, m2_slave_valid,
      output s_addr_tx, s_data_tx, s_valid_s, s_write_en,
      output owner, timeout
   );

   modport master (
      output m1_bus_req, m1_addr_tx, m1_data_tx, m1_valid_s, m1_write_en,
      output m2_bus_req, m2_addr_tx, m2_data_tx, m2_valid_s, m2_write_en,
      output s_data_rx, s_slave_valid,
      input  m1_bus_ready, m2_bus_ready,
      input  m1_data_rx, m2_data_rx, m1_slave_valid, m2_slave_valid,
      input  s_addr_tx, s_data_tx, s_valid_s, s_write_en,
      input  owner, timeout
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and switch for the shared serial bus, with a
// per-grant watchdog, timeout lockout and a RELEASE+IDLE turnaround between owners.
module bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 9
) (
   input  logic          clock,
   input  logic          reset,
   bus_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, RELEASE} state_t;

   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic             last2_q;   // 1: master 2 was the last owner
   logic             lock1_q, lock2_q;
   logic             rdy1_q, rdy2_q, to_q;
   logic [1:0]       owner_q;
   logic             elig1, elig2, wd_exp, own_req;

   always_comb begin
      elig1   = bus.m1_bus_req & ~lock1_q;
      elig2   = bus.m2_bus_req & ~lock2_q;
      wd_exp  = (wd_q == WD_LAST);
      own_req = (state_q == GRANT1) ? bus.m1_bus_req : bus.m2_bus_req;
      wd_d    = (&wd_q) ? wd_q : wd_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         wd_q    <= '0;
         last2_q <= 1'b1;
         lock1_q <= 1'b0;
         lock2_q <= 1'b0;
         rdy1_q  <= 1'b0;
         rdy2_q  <= 1'b0;
         owner_q <= 2'd0;
         to_q    <= 1'b0;
      end else begin
         to_q <= 1'b0;
         if (!bus.m1_bus_req) lock1_q <= 1'b0;
         if (!bus.m2_bus_req) lock2_q <= 1'b0;
         case (state_q)
            IDLE: begin
               wd_q <= '0;
               if (elig1 && (!elig2 || last2_q)) begin
                  state_q <= GRANT1;
                  rdy1_q  <= 1'b1;
                  owner_q <= 2'd1;
               end else if (elig2) begin
                  state_q <= GRANT2;
                  rdy2_q  <= 1'b1;
                  owner_q <= 2'd2;
               end
            end
            GRANT1, GRANT2: begin
               // Expiry wins over a simultaneous request drop, so the lock is still set.
               if (wd_exp || !own_req) begin
                  state_q <= RELEASE;
                  rdy1_q  <= 1'b0;
                  rdy2_q  <= 1'b0;
                  owner_q <= 2'd0;
                  last2_q <= (state_q == GRANT2);
                  if (wd_exp) begin
                     to_q <= 1'b1;
                     if (state_q == GRANT1) lock1_q <= 1'b1;
                     else                   lock2_q <= 1'b1;
                  end
               end else begin
                  wd_q <= wd_d;
               end
            end
            RELEASE: begin
               state_q <= IDLE;
               wd_q    <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.s_addr_tx      = 1'b0;
      bus.s_data_tx      = 1'b0;
      bus.s_valid_s      = 1'b0;
      bus.s_write_en     = 1'b0;
      bus.m1_data_rx     = 1'b0;
      bus.m1_slave_valid = 1'b0;
      bus.m2_data_rx     = 1'b0;
      bus.m2_slave_valid = 1'b0;
      case (owner_q)
         2'd1: begin
            bus.s_addr_tx      = bus.m1_addr_tx;
            bus.s_data_tx      = bus.m1_data_tx;
            bus.s_valid_s      = bus.m1_valid_s;
            bus.s_write_en     = bus.m1_write_en;
            bus.m1_data_rx     = bus.s_data_rx;
            bus.m1_slave_valid = bus.s_slave_valid;
         end
         2'd2: begin
            bus.s_addr_tx      = bus.m2_addr_tx;
            bus.s_data_tx      = bus.m2_data_tx;
            bus.s_valid_s      = bus.m2_valid_s;
            bus.s_write_en     = bus.m2_write_en;
            bus.m2_data_rx     = bus.s_data_rx;
            bus.m2_slave_valid = bus.s_slave_valid;
         end
         default: ;
      endcase
   end

   assign bus.m1_bus_ready = rdy1_q;
   assign bus.m2_bus_ready = rdy2_q;
   assign bus.owner        = owner_q;
   assign bus.timeout      = to_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: per-cycle vector table plus round-robin and watchdog sequences.
module tb_bus_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   bus_arbiter_if bif();
   bus_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (.clock(clock), .reset(reset), .bus(bif));

   // inputs: rst r1 r2 a1 v1 a2 v2 drx dsv | expected: rdy1 rdy2 own sa sv rx1 rx2 sv1 sv2 to
   typedef struct packed {
      logic       rst, r1, r2, a1, v1, a2, v2, drx, dsv;
      logic       rdy1, rdy2;
      logic [1:0] own;
      logic       sa, sv, rx1, rx2, sv1, sv2, to;
   } vec_t;

   localparam int NV = 19;
   vec_t tv [NV];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(string name, int got, int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic drive(vec_t v);
      reset              = v.rst;
      bif.m1_bus_req     = v.r1;
      bif.m2_bus_req     = v.r2;
      bif.m1_addr_tx     = v.a1;
      bif.m1_valid_s     = v.v1;
      bif.m1_data_tx     = ~v.a1;
      bif.m1_write_en    = v.a1 ^ v.v1;
      bif.m2_addr_tx     = v.a2;
      bif.m2_valid_s     = v.v2;
      bif.m2_data_tx     = ~v.a2;
      bif.m2_write_en    = v.a2 ^ v.v2;
      bif.s_data_rx      = v.drx;
      bif.s_slave_valid  = v.dsv;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=hang exp=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [10:0] got, exp;
      logic [1:0]  dw_exp;
      int          w, n;
      bit          hit;

      tv[0]  = 20'b1_00_00_00_00__00_00_00_00_00_0;
      tv[1]  = 20'b0_10_11_00_00__10_01_11_00_00_0;
      tv[2]  = 20'b0_10_01_00_00__10_01_01_00_00_0;
      tv[3]  = 20'b0_10_11_00_11__10_01_11_10_10_0;
      tv[4]  = 20'b0_00_11_00_11__00_00_00_00_00_0;
      tv[5]  = 20'b0_00_00_00_00__00_00_00_00_00_0;
      tv[6]  = 20'b1_00_00_00_00__00_00_00_00_00_0;
      tv[7]  = 20'b0_11_11_00_00__10_01_11_00_00_0;
      tv[8]  = 20'b0_11_01_11_00__10_01_01_00_00_0;
      tv[9]  = 20'b0_01_00_11_00__00_00_00_00_00_0;
      tv[10] = 20'b0_01_00_11_11__00_00_00_00_00_0;
      tv[11] = 20'b0_01_00_11_11__01_10_11_01_01_0;
      tv[12] = 20'b0_01_11_00_01__01_10_00_00_01_0;
      tv[13] = 20'b0_11_00_11_00__01_10_11_00_00_0;
      tv[14] = 20'b0_10_00_00_00__00_00_00_00_00_0;
      tv[15] = 20'b0_10_00_00_00__00_00_00_00_00_0;
      tv[16] = 20'b0_10_11_00_00__10_01_11_00_00_0;
      tv[17] = 20'b1_10_01_00_00__00_00_00_00_00_0;
      tv[18] = 20'b0_00_00_00_00__00_00_00_00_00_0;

      for (int i = 0; i < NV; i++) begin
         drive(tv[i]);
         step();
         got = {bif.m1_bus_ready, bif.m2_bus_ready, bif.owner, bif.s_addr_tx, bif.s_valid_s,
                bif.m1_data_rx, bif.m2_data_rx, bif.m1_slave_valid, bif.m2_slave_valid, bif.timeout};
         exp = {tv[i].rdy1, tv[i].rdy2, tv[i].own, tv[i].sa, tv[i].sv,
                tv[i].rx1, tv[i].rx2, tv[i].sv1, tv[i].sv2, tv[i].to};
         chk($sformatf("vec%0d", i), int'(got), int'(exp));
         if (tv[i].own == 2'd1)      dw_exp = {~tv[i].a1, tv[i].a1 ^ tv[i].v1};
         else if (tv[i].own == 2'd2) dw_exp = {~tv[i].a2, tv[i].a2 ^ tv[i].v2};
         else                        dw_exp = 2'b00;
         chk($sformatf("vec%0d_data_we", i), int'({bif.s_data_tx, bif.s_write_en}), int'(dw_exp));
      end

      // round robin: both request every time, grants must alternate 1,2,1,2
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bif.m1_bus_req = 1'b1;
         bif.m2_bus_req = 1'b1;
         w = 0;
         for (int k = 0; k < 5; k++) begin
            step();
            if (bif.m1_bus_ready || bif.m2_bus_ready) begin
               w = bif.m1_bus_ready ? 1 : 2;
               break;
            end
         end
         chk($sformatf("rr_grant%0d", i), w, (i % 2 == 0) ? 1 : 2);
         chk($sformatf("rr_onehot%0d", i), int'(bif.m1_bus_ready & bif.m2_bus_ready), 0);
         bif.m1_bus_req = 1'b0;
         bif.m2_bus_req = 1'b0;
         repeat (3) step();
      end

      // watchdog: m1 holds its request for longer than the limit
      reset = 1'b1; step(); reset = 1'b0;
      bif.m1_bus_req = 1'b1;
      n = 0; hit = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (bif.timeout) begin hit = 1'b1; break; end
         if (bif.m1_bus_ready) n++;
      end
      chk("to_seen", int'(hit), 1);
      chk("to_grant_cycles", n, 16);
      chk("to_rdy1_low", int'(bif.m1_bus_ready), 0);
      chk("to_owner_none", int'(bif.owner), 0);
      bif.m2_bus_req = 1'b1;
      step();
      chk("to_pulse_one_cycle", int'(bif.timeout), 0);
      chk("to_idle_no_grant", int'(bif.m2_bus_ready), 0);
      step();
      chk("to_m2_granted", int'(bif.m2_bus_ready), 1);
      chk("to_m1_locked_out", int'(bif.m1_bus_ready), 0);
      bif.m2_bus_req = 1'b0;
      repeat (4) step();
      chk("lock_hold", int'(bif.m1_bus_ready), 0);
      bif.m1_bus_req = 1'b0;
      step();
      bif.m1_bus_req = 1'b1;
      hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (bif.m1_bus_ready) begin hit = 1'b1; break; end
      end
      chk("regrant_after_drop", int'(hit), 1);

      // request drop coinciding with watchdog expiry still counts as a timeout
      repeat (15) step();
      chk("sim_last_grant_cycle", int'(bif.m1_bus_ready), 1);
      bif.m1_bus_req = 1'b0;
      step();
      chk("sim_drop_timeout", int'(bif.timeout), 1);
      chk("sim_drop_rdy1_low", int'(bif.m1_bus_ready), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
